// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds words from NREQ requesters
// into a single UART transmitter, one frame at a time.
// Optional WAIT-state watchdog: define UART_ARB_TIMEOUT_EN to enable it.
module uart_tx_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned DBITS          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DBITS-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  tx_start,
    output logic [DBITS-1:0]      tx_data,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Reject out-of-range configurations at elaboration time
    if (NREQ < 2 || NREQ > 8 || DBITS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [IDXW-1:0] ptr, ptr_nx;
    logic [IDXW-1:0] winner, winner_nx;

    logic [NREQ-1:0]  gnt_nx;
    logic [NREQ-1:0]  done_nx;
    logic             tx_start_nx;
    logic [DBITS-1:0] tx_data_nx;
    logic             busy_nx;
    logic             err_nx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Firing when the count equals TIMEOUT_CYCLES-2 means the counter would
    // reach TIMEOUT_CYCLES-1 on the same edge that raises err.
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] wd_cnt, wd_cnt_nx;
`endif

    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;
    int unsigned     scan;

    // Round-robin pick: first requester set at or after ptr, wrapping
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = 32'(ptr) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
            if (!pick_valid && req[IDXW'(scan)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDXW'(scan);
            end
        end
    end

    function automatic logic [IDXW-1:0] ptr_after(input logic [IDXW-1:0] w);
        return (32'(w) == NREQ - 1) ? '0 : w + IDXW'(1);
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        winner_nx   = winner;
        gnt_nx      = '0;
        done_nx     = '0;
        tx_start_nx = 1'b0;
        tx_data_nx  = tx_data;
        err_nx      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        wd_cnt_nx   = wd_cnt;
`endif

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nx    = ISSUE;
                    winner_nx   = pick_idx;
                    gnt_nx      = NREQ'(1) << pick_idx;
                    tx_start_nx = 1'b1;
                    tx_data_nx  = req_data[pick_idx*DBITS +: DBITS];
                end
            end

            ISSUE: begin
                state_nx = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                wd_cnt_nx = '0;
`endif
            end

            WAIT: begin
                if (tx_done) begin
                    state_nx = IDLE;
                    done_nx  = NREQ'(1) << winner;
                    ptr_nx   = ptr_after(winner);
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    state_nx  = IDLE;
                    err_nx    = 1'b1;
                    ptr_nx    = ptr_after(winner);
                    wd_cnt_nx = wd_cnt + CW'(1);
                end else begin
                    wd_cnt_nx = wd_cnt + CW'(1);
                end
`endif
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // State, pointer and winner registers
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            winner <= winner_nx;
        end
    end

    // Registered outputs and watchdog counter
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            gnt      <= '0;
            done     <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
        end else begin
            gnt      <= gnt_nx;
            done     <= done_nx;
            tx_start <= tx_start_nx;
            tx_data  <= tx_data_nx;
            busy     <= busy_nx;
            err      <= err_nx;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt   <= wd_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: grant scoreboard plus a behavioural 8N1
// transmitter (16 clocks per bit) and a serial-line receiver.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DBITS = 8;
    localparam int unsigned TMO   = 16;
    localparam int unsigned TICKS = 16;

    logic                  clk_100MHz = 1'b0;
    logic                  reset_n    = 1'b0;
    logic [NREQ-1:0]       req        = '0;
    logic [NREQ*DBITS-1:0] req_data   = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  tx_start;
    logic [DBITS-1:0]      tx_data;
    logic                  tx_done;
    logic                  busy;
    logic                  err;

    logic tx_done_man = 1'b0;
    logic tx_done_mdl = 1'b0;
    logic auto_tx     = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned      idx;
        logic [DBITS-1:0] data;
    } exp_t;

    exp_t             gq[$];
    logic [DBITS-1:0] rxq[$];

    assign tx_done = auto_tx ? tx_done_mdl : tx_done_man;

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .DBITS(DBITS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset_n(reset_n),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .done(done),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .busy(busy),
        .err(err)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Behavioural 8N1 transmitter
    logic        tx_active = 1'b0;
    logic [9:0]  tx_shift  = '1;
    int unsigned tx_tick   = 0;
    int unsigned tx_bit    = 0;
    logic        serial;

    always @(posedge clk_100MHz) begin
        tx_done_mdl <= 1'b0;
        if (!reset_n) begin
            tx_active <= 1'b0;
        end else if (tx_active) begin
            if (tx_tick == TICKS - 1) begin
                tx_tick <= 0;
                if (tx_bit == 9) begin
                    tx_active   <= 1'b0;
                    tx_done_mdl <= 1'b1;
                end else begin
                    tx_bit   <= tx_bit + 1;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                end
            end else begin
                tx_tick <= tx_tick + 1;
            end
        end else if (auto_tx && tx_start) begin
            tx_active <= 1'b1;
            tx_shift  <= {1'b1, tx_data, 1'b0};
            tx_tick   <= 0;
            tx_bit    <= 0;
        end
    end

    assign serial = tx_active ? tx_shift[0] : 1'b1;

    function automatic logic [NREQ-1:0] oh(input int unsigned i);
        logic [NREQ-1:0] one;
        one = NREQ'(1);
        return one << i;
    endfunction

    task automatic set_word(input int unsigned i, input logic [DBITS-1:0] v);
        req_data[i*DBITS +: DBITS] = v;
    endtask

    task automatic push_gnt(input int unsigned i, input logic [DBITS-1:0] v);
        exp_t e;
        e.idx  = i;
        e.data = v;
        gq.push_back(e);
        set_word(i, v);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        req         = '0;
        tx_done_man = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        reset_n = 1'b1;
    endtask

    task automatic wait_gnt(input int unsigned limit, output bit ok);
        int unsigned n = 0;
        while (gnt === '0 && n < limit) begin
            @(negedge clk_100MHz);
            n++;
        end
        ok = (gnt !== '0);
    endtask

    task automatic wait_done(input int unsigned limit, output bit ok);
        int unsigned n = 0;
        while (done === '0 && n < limit) begin
            @(negedge clk_100MHz);
            n++;
        end
        ok = (done !== '0);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        req         = '0;
        tx_done_man = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (done !== '0) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== '0) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_busy_err got=%b%b exp=00", busy, err); end
        reset_n = 1'b1;
        // tx_done while idle must not produce a done pulse
        @(negedge clk_100MHz);
        tx_done_man = 1'b1;
        @(negedge clk_100MHz);
        tx_done_man = 1'b0;
        checks++; if (done !== '0 || busy !== 1'b0) begin failures++; $display("FAIL idle_tx_done got done=%b busy=%b exp done=0000 busy=0", done, busy); end
    endtask

    task automatic test_single();
        exp_t e;
        push_gnt(2, 8'hA5);
        req = 4'b0100;
        @(negedge clk_100MHz);
        e = gq.pop_front();
        checks++; if (gnt !== oh(e.idx)) begin failures++; $display("FAIL single_gnt got=%b exp=%b", gnt, oh(e.idx)); end
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_tx_start got=%b exp=1", tx_start); end
        checks++; if (tx_data !== e.data) begin failures++; $display("FAIL single_tx_data got=%h exp=%h", tx_data, e.data); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        req         = '0;
        tx_done_man = 1'b1;
        @(negedge clk_100MHz);
        tx_done_man = 1'b0;
        checks++; if (gnt !== '0 || tx_start !== 1'b0) begin failures++; $display("FAIL single_pulse_len got gnt=%b start=%b exp 0000/0", gnt, tx_start); end
        checks++; if (tx_data !== e.data) begin failures++; $display("FAIL single_data_hold got=%h exp=%h", tx_data, e.data); end
        repeat (3) @(negedge clk_100MHz);
        checks++; if (done !== '0 || busy !== 1'b1) begin failures++; $display("FAIL single_issue_tx_done got done=%b busy=%b exp 0000/1", done, busy); end
        tx_done_man = 1'b1;
        @(negedge clk_100MHz);
        tx_done_man = 1'b0;
        checks++; if (done !== oh(e.idx)) begin failures++; $display("FAIL single_done got=%b exp=%b", done, oh(e.idx)); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        @(negedge clk_100MHz);
        checks++; if (done !== '0) begin failures++; $display("FAIL single_done_len got=%b exp=0000", done); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   ok;
        do_reset();
        for (int unsigned k = 0; k < 5; k++) begin
            push_gnt(k % 4, 8'(8'h10 + (k % 4)));
        end
        req = 4'b1111;
        for (int unsigned k = 0; k < 5; k++) begin
            wait_gnt(20, ok);
            e = gq.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL rr_gnt_timeout got=none exp=%b", oh(e.idx)); break; end
            checks++; if (gnt !== oh(e.idx) || tx_data !== e.data) begin failures++; $display("FAIL rr_grant%0d got=%b/%h exp=%b/%h", k, gnt, tx_data, oh(e.idx), e.data); end
            repeat (2) @(negedge clk_100MHz);
            tx_done_man = 1'b1;
            @(negedge clk_100MHz);
            tx_done_man = 1'b0;
            if (k == 4) req = '0;
            checks++; if (done !== oh(e.idx)) begin failures++; $display("FAIL rr_done%0d got=%b exp=%b", k, done, oh(e.idx)); end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        bit   ok;
        push_gnt(3, 8'h13);
        req = 4'b1000;
        for (int unsigned k = 0; k < 3; k++) begin
            wait_gnt(20, ok);
            e = gq.pop_front();
            checks++; if (!ok) begin failures++; $display("FAIL wrap_gnt_timeout got=none exp=%b", oh(e.idx)); break; end
            checks++; if (gnt !== oh(e.idx) || tx_data !== e.data) begin failures++; $display("FAIL wrap_grant%0d got=%b/%h exp=%b/%h", k, gnt, tx_data, oh(e.idx), e.data); end
            repeat (2) @(negedge clk_100MHz);
            tx_done_man = 1'b1;
            @(negedge clk_100MHz);
            tx_done_man = 1'b0;
            if (k == 0) begin
                push_gnt(0, 8'h10);
                push_gnt(3, 8'h13);
                req = 4'b1001;
            end else if (k == 2) begin
                req = '0;
            end
            checks++; if (done !== oh(e.idx)) begin failures++; $display("FAIL wrap_done%0d got=%b exp=%b", k, done, oh(e.idx)); end
        end
    endtask

    task automatic test_withdraw();
        exp_t e;
        bit   ok;
        bit   bad = 1'b0;
        push_gnt(0, 8'h5C);
        req = 4'b0001;
        wait_gnt(20, ok);
        e = gq.pop_front();
        checks++; if (!ok || gnt !== oh(e.idx)) begin failures++; $display("FAIL wd_grant got=%b exp=%b", gnt, oh(e.idx)); end
        req = '0;
        @(negedge clk_100MHz);
        req = 4'b0010;
        repeat (3) @(negedge clk_100MHz);
        req = '0;
        tx_done_man = 1'b1;
        @(negedge clk_100MHz);
        tx_done_man = 1'b0;
        checks++; if (done !== oh(e.idx)) begin failures++; $display("FAIL wd_done got=%b exp=%b", done, oh(e.idx)); end
        repeat (6) begin
            @(negedge clk_100MHz);
            if (gnt !== '0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL withdrawn_req got gnt=%b busy=%b exp none", gnt, busy); end
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        bit   ok;
        bit   bad = 1'b0;
        push_gnt(2, 8'h42);
        req = 4'b0100;
        wait_gnt(20, ok);
        e = gq.pop_front();
        checks++; if (!ok || gnt !== oh(e.idx)) begin failures++; $display("FAIL rst_pre_grant got=%b exp=%b", gnt, oh(e.idx)); end
        req = '0;
        repeat (3) @(negedge clk_100MHz);
        reset_n = 1'b0;
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        checks++; if ({gnt, done, tx_start, tx_data, busy, err} !== '0) begin failures++; $display("FAIL rst_mid_outputs got gnt=%b done=%b start=%b data=%h busy=%b err=%b exp all 0", gnt, done, tx_start, tx_data, busy, err); end
        repeat (4) begin
            @(negedge clk_100MHz);
            if (done !== '0 || err !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL rst_mid_pulse got done=%b err=%b exp none", done, err); end
        push_gnt(0, 8'h99);
        set_word(1, 8'h11);
        set_word(2, 8'h22);
        set_word(3, 8'h33);
        req = 4'b1111;
        wait_gnt(20, ok);
        e = gq.pop_front();
        req = '0;
        checks++; if (!ok || gnt !== oh(e.idx) || tx_data !== e.data) begin failures++; $display("FAIL rst_ptr_zero got=%b/%h exp=%b/%h", gnt, tx_data, oh(e.idx), e.data); end
        repeat (2) @(negedge clk_100MHz);
        tx_done_man = 1'b1;
        @(negedge clk_100MHz);
        tx_done_man = 1'b0;
        checks++; if (done !== oh(e.idx)) begin failures++; $display("FAIL rst_post_done got=%b exp=%b", done, oh(e.idx)); end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        exp_t e;
        bit   ok;
        bit   bad = 1'b0;
        do_reset();
        push_gnt(0, 8'h77);
        req = 4'b0001;
        wait_gnt(20, ok);
        e = gq.pop_front();
        req = '0;
        checks++; if (!ok || gnt !== oh(e.idx)) begin failures++; $display("FAIL tmo_grant got=%b exp=%b", gnt, oh(e.idx)); end
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_100MHz);
            if (err !== 1'b0 || busy !== 1'b1 || done !== '0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL tmo_early got err=%b busy=%b exp 0/1", err, busy); end
        @(negedge clk_100MHz);
        checks++; if (err !== 1'b1 || done !== '0 || busy !== 1'b0) begin failures++; $display("FAIL tmo_err got err=%b done=%b busy=%b exp 1/0000/0", err, done, busy); end
        @(negedge clk_100MHz);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_len got=%b exp=0", err); end
        push_gnt(0, 8'h78);
        req = 4'b0001;
        wait_gnt(20, ok);
        e = gq.pop_front();
        req = '0;
        checks++; if (!ok || gnt !== oh(e.idx)) begin failures++; $display("FAIL tmo_grant2 got=%b exp=%b", gnt, oh(e.idx)); end
        repeat (15) @(negedge clk_100MHz);
        tx_done_man = 1'b1;
        @(negedge clk_100MHz);
        tx_done_man = 1'b0;
        checks++; if (done !== oh(e.idx) || err !== 1'b0) begin failures++; $display("FAIL tmo_tie got done=%b err=%b exp %b/0", done, err, oh(e.idx)); end
    endtask
`else
    task automatic test_watchdog();
        exp_t e;
        bit   ok;
        bit   bad = 1'b0;
        do_reset();
        push_gnt(0, 8'h77);
        req = 4'b0001;
        wait_gnt(20, ok);
        e = gq.pop_front();
        req = '0;
        checks++; if (!ok || gnt !== oh(e.idx)) begin failures++; $display("FAIL nowd_grant got=%b exp=%b", gnt, oh(e.idx)); end
        repeat (40) begin
            @(negedge clk_100MHz);
            if (err !== 1'b0 || busy !== 1'b1 || done !== '0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL nowd_wait got err=%b busy=%b exp 0/1", err, busy); end
        tx_done_man = 1'b1;
        @(negedge clk_100MHz);
        tx_done_man = 1'b0;
        checks++; if (done !== oh(e.idx) || err !== 1'b0) begin failures++; $display("FAIL nowd_done got done=%b err=%b exp %b/0", done, err, oh(e.idx)); end
    endtask
`endif

    task automatic test_back_to_back();
        do_reset();
        auto_tx = 1'b1;
        push_gnt(0, 8'h3C);
        push_gnt(1, 8'hC5);
        rxq.push_back(8'h3C);
        rxq.push_back(8'hC5);
        req = 4'b0011;
        fork
            begin : grants
                exp_t e;
                bit   ok;
                for (int unsigned k = 0; k < 2; k++) begin
                    wait_gnt(400, ok);
                    e = gq.pop_front();
                    if (k == 1) req = '0;
                    checks++; if (!ok || gnt !== oh(e.idx) || tx_data !== e.data) begin failures++; $display("FAIL b2b_grant%0d got=%b/%h exp=%b/%h", k, gnt, tx_data, oh(e.idx), e.data); end
                    wait_done(400, ok);
                    checks++; if (!ok || done !== oh(e.idx)) begin failures++; $display("FAIL b2b_done%0d got=%b exp=%b", k, done, oh(e.idx)); end
                end
            end
            begin : receiver
                logic [DBITS-1:0] got;
                logic [DBITS-1:0] exp_b;
                int unsigned      n;
                for (int unsigned f = 0; f < 2; f++) begin
                    n = 0;
                    while (serial !== 1'b0 && n < 400) begin
                        @(negedge clk_100MHz);
                        n++;
                    end
                    if (f == 1) begin
                        checks++; if (n > 32) begin failures++; $display("FAIL b2b_gap got=%0d exp<=32", n); end
                    end
                    repeat (TICKS / 2) @(negedge clk_100MHz);
                    checks++; if (serial !== 1'b0) begin failures++; $display("FAIL b2b_start%0d got=%b exp=0", f, serial); end
                    for (int unsigned b = 0; b < DBITS; b++) begin
                        repeat (TICKS) @(negedge clk_100MHz);
                        got[b] = serial;
                    end
                    repeat (TICKS) @(negedge clk_100MHz);
                    checks++; if (serial !== 1'b1) begin failures++; $display("FAIL b2b_stop%0d got=%b exp=1", f, serial); end
                    exp_b = rxq.pop_front();
                    checks++; if (got !== exp_b) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", f, got, exp_b); end
                end
            end
        join
        auto_tx = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=stuck exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_withdraw();
        test_reset_mid_wait();
        test_watchdog();
        test_back_to_back();
        repeat (4) @(negedge clk_100MHz);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
